// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu core fetch path.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP      = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// Circular FIFO of fetched {instr, pc} entries; head is read straight from storage.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     wr_entry,
  output logic [PTR_W-1:0] count,
  output fetch_entry_t     head
);
  localparam int               IDX_W    = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1'b1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign count     = wr_ptr_r - rd_ptr_r;
  assign do_pop_s  = pop && (count != '0);
  assign do_push_s = push && ((count != FULL_CNT) || do_pop_s);
  assign head      = mem_r[rd_ptr_r[IDX_W-1:0]];

  // Pointer update; clear discards every stored entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
    end
  end

  // Entry storage, zeroed on reset so the head reads 0 before the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s && !clear) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= wr_entry;
    end
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: owns the sequential fetch PC, requests words from instruction
// memory and queues them with their PCs for decode; redirects flush and refetch.
module instr_fetch_buffer
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  fetch_pc
);
  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_t      state_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [CNT_W-1:0]  count_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_entry_s;
  logic              run_s;
  logic              req_s;
  logic              valid_s;
  logic              push_s;
  logic              pop_s;

  // Request and valid decode only from registered state, never from out_ready.
  assign run_s        = (state_r == RUN);
  assign req_s        = run_s && (count_s < FULL_CNT);
  assign valid_s      = run_s && (count_s != '0);
  assign push_s       = req_s && imem_ack && !redirect;
  assign pop_s        = valid_s && out_ready;
  assign push_entry_s = '{instr: imem_rdata, pc: fetch_pc_r};

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .clear   (redirect),
    .wr_entry(push_entry_s),
    .count   (count_s),
    .head    (head_s)
  );

  // Fetch state machine and sequential fetch address; redirect overrides all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= FLUSH;
      fetch_pc_r <= word_align(RESET_PC);
    end else begin
      case (state_r)
        FLUSH:   state_r <= redirect ? FLUSH : RUN;
        RUN:     state_r <= redirect ? FLUSH : RUN;
        default: state_r <= FLUSH;
      endcase
      if (redirect) begin
        fetch_pc_r <= word_align(redirect_pc);
      end else if (push_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;
  assign out_valid = valid_s;
  assign out_instr = head_s.instr;
  assign out_pc    = head_s.pc;
  assign fetch_pc  = fetch_pc_r;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: vector table plus scoreboard model.
module tb_instr_fetch_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  typedef struct {
    bit          do_rst;
    bit          ready;
    bit          exp_valid;
    bit          exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_fpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic [31:0] fetch_pc;

  logic        ack_all = 1'b1;
  logic        lat_mode = 1'b0;
  int          wait_cnt = 0;
  int          wait_nxt = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  sb_t         sb[$];
  logic [31:0] model_pc = 32'h0000_0000;
  bit          model_run = 1'b0;
  logic [31:0] pop_pc[$];
  int          pop_cyc[$];
  vec_t        vecs[20];

  // Memory model: ack every cycle, or after the request has waited two cycles.
  assign imem_ack   = ack_all | (lat_mode & imem_req & (wait_cnt >= 2));
  assign imem_rdata = imem_addr + 32'h0000_1000;

  always #5 clk = ~clk;

  instr_fetch_buffer #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .fetch_pc   (fetch_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),  32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_instr"}, out_instr,      32'd0);
    check({tag, "_pc"},    out_pc,         32'd0);
    check({tag, "_fpc"},   fetch_pc,       32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    model_pc  = 32'h0000_0000;
    model_run = 1'b0;
    wait_cnt  = 0;
    wait_nxt  = 0;
  endtask

  task automatic do_reset();
    redirect = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Sampled mid-cycle: compare against the model, then apply the coming edge's effects.
  task automatic score();
    logic exp_v;
    logic exp_r;
    sb_t  e;
    exp_v = model_run && (sb.size() != 0);
    exp_r = model_run && (sb.size() < DEPTH);
    check("out_valid", 32'(out_valid), 32'(exp_v));
    check("imem_req",  32'(imem_req),  32'(exp_r));
    check("fetch_pc",  fetch_pc,       model_pc);
    if (exp_r) check("imem_addr", imem_addr, model_pc);
    if (exp_v && out_ready) begin
      e = sb.pop_front();
      check("sb_pc",    out_pc,    e.pc);
      check("sb_instr", out_instr, e.instr);
      pop_pc.push_back(out_pc);
      pop_cyc.push_back(cyc);
    end
    if (exp_r && imem_ack && !redirect) begin
      sb.push_back('{instr: model_pc + 32'h0000_1000, pc: model_pc});
      model_pc = model_pc + 32'd4;
    end
    wait_nxt = (imem_req && !imem_ack && !redirect) ? wait_cnt + 1 : 0;
    if (redirect) begin
      sb.delete();
      model_pc = {redirect_pc[31:2], 2'b00};
    end
    model_run = !redirect;
  endtask

  task automatic tick();
    @(negedge clk);
    score();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    wait_cnt = wait_nxt;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      adv();
    end
  endtask

  initial begin
    // Zero-wait streaming, then back-pressure until full and drain.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  32'd4};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  32'd8};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd8,  32'd12};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  32'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  32'd8};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  32'd12};
    for (int i = 10; i < 15; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd16};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  32'd16};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  32'd16};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd8,  32'd20};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 32'd24};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 32'd28};

    #2;
    ack_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].do_rst) do_reset();
      out_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_req", i),   32'(imem_req),  32'(vecs[i].exp_req));
      check($sformatf("vec%0d_fpc", i),   fetch_pc,       vecs[i].exp_fpc);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      adv();
    end

    // Three-cycle memory latency.
    do_reset();
    ack_all = 1'b0;
    lat_mode = 1'b1;
    out_ready = 1'b1;
    pop_pc.delete();
    pop_cyc.delete();
    run(12);
    check("lat_npops", 32'(pop_pc.size()), 32'd3);
    if (pop_pc.size() == 3) begin
      for (int k = 0; k < 3; k++) check($sformatf("lat_pc%0d", k), pop_pc[k], 32'(k * 4));
      for (int k = 1; k < 3; k++) check($sformatf("lat_gap%0d", k), 32'(pop_cyc[k] - pop_cyc[k-1]), 32'd3);
    end

    // Redirect with three entries buffered and an ack in the same cycle.
    do_reset();
    ack_all = 1'b1;
    lat_mode = 1'b0;
    out_ready = 1'b0;
    run(4);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    out_ready = 1'b1;
    tick();
    check("rdr_ack_seen", 32'(imem_req && imem_ack), 32'd1);
    adv();
    redirect = 1'b0;
    tick();
    check("rdr_flush_valid", 32'(out_valid), 32'd0);
    check("rdr_flush_req",   32'(imem_req),  32'd0);
    adv();
    tick();
    check("rdr_addr", imem_addr, 32'h0000_0100);
    adv();
    tick();
    check("rdr_valid", 32'(out_valid), 32'd1);
    check("rdr_pc",    out_pc,         32'h0000_0100);
    adv();

    // Back-to-back redirects: the second one wins and the flush is extended.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    adv();
    redirect_pc = 32'h0000_0207;
    tick();
    adv();
    redirect = 1'b0;
    tick();
    check("dbl_flush_req", 32'(imem_req), 32'd0);
    adv();
    tick();
    check("dbl_addr", imem_addr, 32'h0000_0204);
    adv();
    tick();
    check("dbl_pc", out_pc, 32'h0000_0204);
    adv();

    // Address wrap at the top of memory.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    adv();
    redirect = 1'b0;
    pop_pc.delete();
    run(5);
    check("wrap_npops", 32'(pop_pc.size() >= 2), 32'd1);
    if (pop_pc.size() >= 2) begin
      check("wrap_pc0", pop_pc[0], 32'hFFFF_FFFC);
      check("wrap_pc1", pop_pc[1], 32'h0000_0000);
    end

    // Asynchronous reset while a request is pending and two entries are held.
    do_reset();
    ack_all = 1'b1;
    out_ready = 1'b0;
    run(3);
    ack_all = 1'b0;
    tick();
    check("mid_pre_req",   32'(imem_req), 32'd1);
    check("mid_pre_instr", out_instr,     32'h0000_1000);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ack_all = 1'b1;
    out_ready = 1'b1;
    pop_pc.delete();
    run(5);
    check("mid_npops", 32'(pop_pc.size() >= 1), 32'd1);
    if (pop_pc.size() >= 1) check("mid_restart_pc", pop_pc[0], 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
